// File: rtl/instr_fetch_unit_if.sv
// Fetch-control bus between the pipeline controller and the fetch unit.
// The slave side is the fetch unit; the master side drives stall and redirects.
interface instr_fetch_unit_if;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] address;
  logic [31:0] pc_out;
  logic        fetch_valid;
  logic        done;
  logic [31:0] fetch_count;

  modport master (
    output stall, branch_taken, branch_target, jump, jump_target,
    input  address, pc_out, fetch_valid, done, fetch_count
  );

  modport slave (
    input  stall, branch_taken, branch_target, jump, jump_target,
    output address, pc_out, fetch_valid, done, fetch_count
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// PC register and fetch control feeding a one-cycle registered instruction memory.
// Tracks the PC of the memory output, squashes redirected fetches, halts past MEM_SIZE.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] MEM_SIZE = 32'd15
) (
  input  logic                  clk,
  input  logic                  reset,
  instr_fetch_unit_if.slave     bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        valid_q, valid_d;
  logic [31:0] count_q, count_d;
  logic [31:0] pc_inc;
  logic [31:0] redir_target;
  logic        redirect;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      pc_out_q <= 32'd0;
      valid_q  <= 1'b0;
      count_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
      count_q  <= count_d;
    end
  end

  assign pc_inc       = pc_q + 32'd1;
  assign redirect     = bus.jump | bus.branch_taken;
  // jump outranks branch when both fire in the same cycle
  assign redir_target = bus.jump ? bus.jump_target : bus.branch_target;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_out_d = pc_out_q;
    valid_d  = 1'b0;
    count_d  = count_q;
    if (redirect) begin
      // The fetch in flight at this edge belongs to the old path and is squashed.
      pc_d    = redir_target;
      state_d = (redir_target > MEM_SIZE) ? DONE : RUN;
    end else if (state_q == DONE) begin
      state_d = DONE;
    end else if (bus.stall) begin
      state_d = STALL;
    end else begin
      pc_out_d = pc_q;
      valid_d  = 1'b1;
      pc_d     = pc_inc;
      count_d  = count_q + 32'd1;
      state_d  = (pc_inc > MEM_SIZE) ? DONE : RUN;
    end
  end

  assign bus.address     = pc_q;
  assign bus.pc_out      = pc_out_q;
  assign bus.fetch_valid = valid_q;
  assign bus.done        = (state_q == DONE);
  assign bus.fetch_count = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with RESET_PC=0, MEM_SIZE=15.
// Inputs change 1ns after each rising edge; outputs are sampled at that same point.
module tb_instr_fetch_unit;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  instr_fetch_unit_if ifc ();

  instr_fetch_unit #(.RESET_PC(32'd0), .MEM_SIZE(32'd15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifc.stall         = 1'b0;
    ifc.branch_taken  = 1'b0;
    ifc.branch_target = 32'd0;
    ifc.jump          = 1'b0;
    ifc.jump_target   = 32'd0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ifc.address !== 32'd0) begin errors++; $display("FAIL reset_address got %0d exp 0", ifc.address); end
    checks++; if (ifc.pc_out !== 32'd0) begin errors++; $display("FAIL reset_pc_out got %0d exp 0", ifc.pc_out); end
    checks++; if (ifc.fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", ifc.fetch_valid); end
    checks++; if (ifc.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", ifc.done); end
    checks++; if (ifc.fetch_count !== 32'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", ifc.fetch_count); end
  endtask

  task automatic test_free_run();
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++; if (ifc.address !== 32'(k)) begin errors++; $display("FAIL run_address[%0d] got %0d exp %0d", k, ifc.address, k); end
      checks++; if (ifc.pc_out !== 32'(k - 1)) begin errors++; $display("FAIL run_pc_out[%0d] got %0d exp %0d", k, ifc.pc_out, k - 1); end
      checks++; if (ifc.fetch_valid !== 1'b1) begin errors++; $display("FAIL run_valid[%0d] got %b exp 1", k, ifc.fetch_valid); end
      checks++; if (ifc.fetch_count !== 32'(k)) begin errors++; $display("FAIL run_count[%0d] got %0d exp %0d", k, ifc.fetch_count, k); end
    end
  endtask

  // Entered with PC=5, pc_out=4, count=5.
  task automatic test_stall();
    ifc.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (ifc.address !== 32'd5) begin errors++; $display("FAIL stall_address[%0d] got %0d exp 5", k, ifc.address); end
      checks++; if (ifc.pc_out !== 32'd4) begin errors++; $display("FAIL stall_pc_out[%0d] got %0d exp 4", k, ifc.pc_out); end
      checks++; if (ifc.fetch_valid !== 1'b0) begin errors++; $display("FAIL stall_valid[%0d] got %b exp 0", k, ifc.fetch_valid); end
      checks++; if (ifc.fetch_count !== 32'd5) begin errors++; $display("FAIL stall_count[%0d] got %0d exp 5", k, ifc.fetch_count); end
    end
    ifc.stall = 1'b0;
    step();
    checks++; if (ifc.pc_out !== 32'd5) begin errors++; $display("FAIL unstall_pc_out got %0d exp 5", ifc.pc_out); end
    checks++; if (ifc.fetch_valid !== 1'b1) begin errors++; $display("FAIL unstall_valid got %b exp 1", ifc.fetch_valid); end
    checks++; if (ifc.address !== 32'd6) begin errors++; $display("FAIL unstall_address got %0d exp 6", ifc.address); end
    checks++; if (ifc.fetch_count !== 32'd6) begin errors++; $display("FAIL unstall_count got %0d exp 6", ifc.fetch_count); end
    step();
    checks++; if (ifc.pc_out !== 32'd6) begin errors++; $display("FAIL after_unstall_pc_out got %0d exp 6", ifc.pc_out); end
    checks++; if (ifc.address !== 32'd7) begin errors++; $display("FAIL after_unstall_address got %0d exp 7", ifc.address); end
  endtask

  task automatic test_branch();
    do_reset();
    step(); step(); step();
    checks++; if (ifc.address !== 32'd3) begin errors++; $display("FAIL pre_branch_address got %0d exp 3", ifc.address); end
    ifc.branch_taken  = 1'b1;
    ifc.branch_target = 32'd10;
    step();
    clear_inputs();
    checks++; if (ifc.address !== 32'd10) begin errors++; $display("FAIL branch_address got %0d exp 10", ifc.address); end
    checks++; if (ifc.fetch_valid !== 1'b0) begin errors++; $display("FAIL branch_squash got %b exp 0", ifc.fetch_valid); end
    checks++; if (ifc.pc_out !== 32'd2) begin errors++; $display("FAIL branch_pc_out_hold got %0d exp 2", ifc.pc_out); end
    checks++; if (ifc.fetch_count !== 32'd3) begin errors++; $display("FAIL branch_count got %0d exp 3", ifc.fetch_count); end
    step();
    checks++; if (ifc.pc_out !== 32'd10) begin errors++; $display("FAIL branch_dest_pc_out got %0d exp 10", ifc.pc_out); end
    checks++; if (ifc.fetch_valid !== 1'b1) begin errors++; $display("FAIL branch_dest_valid got %b exp 1", ifc.fetch_valid); end
    checks++; if (ifc.address !== 32'd11) begin errors++; $display("FAIL branch_dest_address got %0d exp 11", ifc.address); end
    checks++; if (ifc.fetch_count !== 32'd4) begin errors++; $display("FAIL branch_dest_count got %0d exp 4", ifc.fetch_count); end
  endtask

  // Entered with PC=11, count=4.
  task automatic test_jump_branch_stall();
    ifc.jump          = 1'b1;
    ifc.jump_target   = 32'd2;
    ifc.branch_taken  = 1'b1;
    ifc.branch_target = 32'd9;
    ifc.stall         = 1'b1;
    step();
    ifc.jump         = 1'b0;
    ifc.branch_taken = 1'b0;
    checks++; if (ifc.address !== 32'd2) begin errors++; $display("FAIL jb_address got %0d exp 2", ifc.address); end
    checks++; if (ifc.fetch_valid !== 1'b0) begin errors++; $display("FAIL jb_valid got %b exp 0", ifc.fetch_valid); end
    step();
    checks++; if (ifc.address !== 32'd2) begin errors++; $display("FAIL jb_stall_address got %0d exp 2", ifc.address); end
    checks++; if (ifc.fetch_valid !== 1'b0) begin errors++; $display("FAIL jb_stall_valid got %b exp 0", ifc.fetch_valid); end
    ifc.stall = 1'b0;
    step();
    checks++; if (ifc.pc_out !== 32'd2) begin errors++; $display("FAIL jb_pc_out got %0d exp 2", ifc.pc_out); end
    checks++; if (ifc.fetch_valid !== 1'b1) begin errors++; $display("FAIL jb_release_valid got %b exp 1", ifc.fetch_valid); end
    checks++; if (ifc.fetch_count !== 32'd5) begin errors++; $display("FAIL jb_count got %0d exp 5", ifc.fetch_count); end
  endtask

  // Entered with count=5.
  task automatic test_done();
    ifc.jump        = 1'b1;
    ifc.jump_target = 32'd13;
    step();
    clear_inputs();
    checks++; if (ifc.address !== 32'd13) begin errors++; $display("FAIL done_setup_address got %0d exp 13", ifc.address); end
    for (int k = 13; k <= 15; k++) begin
      step();
      checks++; if (ifc.pc_out !== 32'(k)) begin errors++; $display("FAIL tail_pc_out[%0d] got %0d exp %0d", k, ifc.pc_out, k); end
      checks++; if (ifc.fetch_valid !== 1'b1) begin errors++; $display("FAIL tail_valid[%0d] got %b exp 1", k, ifc.fetch_valid); end
      checks++; if (ifc.done !== (k == 15)) begin errors++; $display("FAIL tail_done[%0d] got %b exp %b", k, ifc.done, k == 15); end
    end
    checks++; if (ifc.fetch_count !== 32'd8) begin errors++; $display("FAIL tail_count got %0d exp 8", ifc.fetch_count); end
    for (int k = 0; k < 5; k++) begin
      ifc.stall = k[0];
      step();
      checks++; if (ifc.done !== 1'b1) begin errors++; $display("FAIL halt_done[%0d] got %b exp 1", k, ifc.done); end
      checks++; if (ifc.fetch_valid !== 1'b0) begin errors++; $display("FAIL halt_valid[%0d] got %b exp 0", k, ifc.fetch_valid); end
      checks++; if (ifc.address !== 32'd16) begin errors++; $display("FAIL halt_address[%0d] got %0d exp 16", k, ifc.address); end
      checks++; if (ifc.fetch_count !== 32'd8) begin errors++; $display("FAIL halt_count[%0d] got %0d exp 8", k, ifc.fetch_count); end
    end
    clear_inputs();
    ifc.jump        = 1'b1;
    ifc.jump_target = 32'd0;
    step();
    clear_inputs();
    checks++; if (ifc.done !== 1'b0) begin errors++; $display("FAIL exit_done got %b exp 0", ifc.done); end
    checks++; if (ifc.address !== 32'd0) begin errors++; $display("FAIL exit_address got %0d exp 0", ifc.address); end
    step();
    checks++; if (ifc.pc_out !== 32'd0) begin errors++; $display("FAIL exit_pc_out got %0d exp 0", ifc.pc_out); end
    checks++; if (ifc.fetch_valid !== 1'b1) begin errors++; $display("FAIL exit_valid got %b exp 1", ifc.fetch_valid); end
    checks++; if (ifc.fetch_count !== 32'd9) begin errors++; $display("FAIL exit_count got %0d exp 9", ifc.fetch_count); end
    // Out-of-range redirect target halts directly; large value exercises the unsigned compare.
    ifc.branch_taken  = 1'b1;
    ifc.branch_target = 32'h8000_0000;
    step();
    clear_inputs();
    checks++; if (ifc.done !== 1'b1) begin errors++; $display("FAIL far_redirect_done got %b exp 1", ifc.done); end
    checks++; if (ifc.address !== 32'h8000_0000) begin errors++; $display("FAIL far_redirect_address got %h exp 80000000", ifc.address); end
    step();
    checks++; if (ifc.fetch_valid !== 1'b0) begin errors++; $display("FAIL far_redirect_valid got %b exp 0", ifc.fetch_valid); end
    checks++; if (ifc.address !== 32'h8000_0000) begin errors++; $display("FAIL far_redirect_hold got %h exp 80000000", ifc.address); end
  endtask

  task automatic test_reset_in_stall();
    do_reset();
    for (int k = 0; k < 7; k++) step();
    ifc.stall = 1'b1;
    step();
    checks++; if (ifc.address !== 32'd7) begin errors++; $display("FAIL rs_pre_address got %0d exp 7", ifc.address); end
    checks++; if (ifc.fetch_count !== 32'd7) begin errors++; $display("FAIL rs_pre_count got %0d exp 7", ifc.fetch_count); end
    reset = 1'b1;
    step();
    checks++; if (ifc.address !== 32'd0) begin errors++; $display("FAIL rs_address got %0d exp 0", ifc.address); end
    checks++; if (ifc.fetch_count !== 32'd0) begin errors++; $display("FAIL rs_count got %0d exp 0", ifc.fetch_count); end
    checks++; if (ifc.fetch_valid !== 1'b0) begin errors++; $display("FAIL rs_valid got %b exp 0", ifc.fetch_valid); end
    checks++; if (ifc.done !== 1'b0) begin errors++; $display("FAIL rs_done got %b exp 0", ifc.done); end
    checks++; if (ifc.pc_out !== 32'd0) begin errors++; $display("FAIL rs_pc_out got %0d exp 0", ifc.pc_out); end
    reset = 1'b0;
    ifc.stall = 1'b0;
    step();
    checks++; if (ifc.pc_out !== 32'd0) begin errors++; $display("FAIL rs_resume_pc_out got %0d exp 0", ifc.pc_out); end
    checks++; if (ifc.fetch_valid !== 1'b1) begin errors++; $display("FAIL rs_resume_valid got %b exp 1", ifc.fetch_valid); end
    checks++; if (ifc.address !== 32'd1) begin errors++; $display("FAIL rs_resume_address got %0d exp 1", ifc.address); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    clear_inputs();
    test_reset();
    test_free_run();
    test_stall();
    test_branch();
    test_jump_branch_stall();
    test_done();
    test_reset_in_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
